// File: rtl/reg_file_sb.sv
// Register file with optional write-to-read forwarding and a shift-register
// hazard scoreboard that produces combinational pause/stall for dependent reads.
module reg_file_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int HAZ_DEPTH = 3,
  parameter int BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              RegWE,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [1:0]        pause,
  output logic              stall,
  output logic [3:0]        inflight
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  // With forwarding, the oldest entry writes back in the same cycle it is read.
  localparam int WIN = (BYPASS != 0) ? (HAZ_DEPTH - 1) : HAZ_DEPTH;
  localparam logic [3:0] HAZ_DEPTH_W = 4'(HAZ_DEPTH);

  logic [DATA_W-1:0]    r_regs [NUM_REGS];
  logic [HAZ_DEPTH-1:0] r_sb_valid;
  logic [ADDR_W-1:0]    r_sb_addr [HAZ_DEPTH];
  logic [3:0]           r_inflight;

  logic [HAZ_DEPTH-1:0] w_sb_valid_nxt;
  logic                 w_issue_ok;
  logic                 w_pause_rs;
  logic                 w_pause_rt;
  logic [3:0]           w_cnt;
  logic [3:0]           w_inflight_nxt;
  logic [DATA_W-1:0]    w_rd1;
  logic [DATA_W-1:0]    w_rd2;

  // Register file storage: sync reset clears everything and wins over writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (RegWE && (write_addr != {ADDR_W{1'b0}})) begin
      r_regs[write_addr] <= write_data;
    end else begin
      r_regs[write_addr] <= r_regs[write_addr];
    end
  end

  // Combinational read ports with r0 hardwired to zero and optional forwarding.
  always_comb begin
    w_rd1 = r_regs[read_addr1];
    w_rd2 = r_regs[read_addr2];
    if (read_addr1 == {ADDR_W{1'b0}}) begin
      w_rd1 = '0;
    end else if ((BYPASS != 0) && RegWE && (write_addr == read_addr1)) begin
      w_rd1 = write_data;
    end else begin
      w_rd1 = r_regs[read_addr1];
    end
    if (read_addr2 == {ADDR_W{1'b0}}) begin
      w_rd2 = '0;
    end else if ((BYPASS != 0) && RegWE && (write_addr == read_addr2)) begin
      w_rd2 = write_data;
    end else begin
      w_rd2 = r_regs[read_addr2];
    end
  end

  // Hazard detection against the window of younger scoreboard entries.
  always_comb begin
    w_pause_rs = 1'b0;
    w_pause_rt = 1'b0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      if ((k < WIN) && r_sb_valid[k]) begin
        if (rs_used && (read_addr1 != {ADDR_W{1'b0}}) && (r_sb_addr[k] == read_addr1)) begin
          w_pause_rs = 1'b1;
        end else begin
          w_pause_rs = w_pause_rs;
        end
        if (rt_used && (read_addr2 != {ADDR_W{1'b0}}) && (r_sb_addr[k] == read_addr2)) begin
          w_pause_rt = 1'b1;
        end else begin
          w_pause_rt = w_pause_rt;
        end
      end else begin
        w_pause_rs = w_pause_rs;
        w_pause_rt = w_pause_rt;
      end
    end
  end

  assign pause = {w_pause_rt, w_pause_rs};
  assign stall = w_pause_rt | w_pause_rs;
  // A stalled issue is dropped; the issuing stage re-presents it later.
  assign w_issue_ok = issue_valid && (issue_addr != {ADDR_W{1'b0}}) && !stall;

  // Next scoreboard valid vector and its population count for inflight.
  always_comb begin
    w_sb_valid_nxt    = '0;
    w_sb_valid_nxt[0] = w_issue_ok;
    for (int k = 1; k < HAZ_DEPTH; k++) begin
      w_sb_valid_nxt[k] = r_sb_valid[k-1];
    end
    w_cnt = 4'd0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      w_cnt = w_cnt + {3'b000, w_sb_valid_nxt[k]};
    end
    if (w_cnt > HAZ_DEPTH_W) begin
      w_inflight_nxt = HAZ_DEPTH_W;
    end else begin
      w_inflight_nxt = w_cnt;
    end
  end

  // Scoreboard shift register (entry 0 youngest) and registered occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sb_valid <= '0;
      r_inflight <= 4'd0;
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        r_sb_addr[k] <= '0;
      end
    end else begin
      r_sb_valid   <= w_sb_valid_nxt;
      r_inflight   <= w_inflight_nxt;
      r_sb_addr[0] <= w_issue_ok ? issue_addr : {ADDR_W{1'b0}};
      for (int k = 1; k < HAZ_DEPTH; k++) begin
        r_sb_addr[k] <= r_sb_addr[k-1];
      end
    end
  end

  assign read_data1 = w_rd1;
  assign read_data2 = w_rd2;
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; a second instance with
// forwarding disabled checks the non-bypass read path.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic        rs_used;
  logic        rt_used;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        RegWE;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [1:0]  pause_b, pause_n;
  logic        stall_b, stall_n;
  logic [3:0]  infl_b, infl_n;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .HAZ_DEPTH(3), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .rs_used(rs_used), .rt_used(rt_used), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .RegWE(RegWE), .write_addr(write_addr),
    .write_data(write_data), .read_data1(rd1_b), .read_data2(rd2_b),
    .pause(pause_b), .stall(stall_b), .inflight(infl_b)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .HAZ_DEPTH(3), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .rs_used(rs_used), .rt_used(rt_used), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .RegWE(RegWE), .write_addr(write_addr),
    .write_data(write_data), .read_data1(rd1_n), .read_data2(rd2_n),
    .pause(pause_n), .stall(stall_n), .inflight(infl_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; read_addr1 = 5'd0; read_addr2 = 5'd0; rs_used = 1'b0; rt_used = 1'b0;
    issue_valid = 1'b0; issue_addr = 5'd0; RegWE = 1'b0; write_addr = 5'd0;
    write_data = 32'd0;
    step();
    rst = 1'b1;
    read_addr1 = 5'd5;
    #1;
    chk("reset_rd1_r5", rd1_b, 32'd0);
    chk("reset_pause", {30'd0, pause_b}, 32'd0);
    chk("reset_stall", {31'd0, stall_b}, 32'd0);
    chk("reset_inflight", {28'd0, infl_b}, 32'd0);

    // Write r7, read back next cycle.
    RegWE = 1'b1; write_addr = 5'd7; write_data = 32'hDEADBEEF;
    step();
    RegWE = 1'b0; read_addr1 = 5'd7;
    #1;
    chk("rd_r7", rd1_b, 32'hDEADBEEF);

    // r0 writes are ignored, including the forwarding path.
    RegWE = 1'b1; write_addr = 5'd0; write_data = 32'h00001234; read_addr1 = 5'd0;
    #1;
    chk("r0_no_bypass", rd1_b, 32'd0);
    step();
    RegWE = 1'b0;
    #1;
    chk("rd_r0", rd1_b, 32'd0);

    // Same-cycle write and read of r9.
    RegWE = 1'b1; write_addr = 5'd9; write_data = 32'hA5A5A5A5; read_addr2 = 5'd9;
    #1;
    chk("bypass_rd2", rd2_b, 32'hA5A5A5A5);
    chk("nobypass_rd2_old", rd2_n, 32'd0);
    step();
    RegWE = 1'b0;
    #1;
    chk("bypass_rd2_after", rd2_b, 32'hA5A5A5A5);
    chk("nobypass_rd2_after", rd2_n, 32'hA5A5A5A5);
    read_addr2 = 5'd0;

    // Issue to r0 never occupies the scoreboard.
    issue_valid = 1'b1; issue_addr = 5'd0;
    step();
    chk("issue_r0_inflight", {28'd0, infl_b}, 32'd0);

    // RAW hazard on rs: stall two cycles, inflight 1,1,1,0.
    issue_addr = 5'd3;
    step();
    issue_valid = 1'b0;
    chk("haz_inflight_0", {28'd0, infl_b}, 32'd1);
    read_addr1 = 5'd3; rs_used = 1'b1;
    #1;
    chk("haz_pause_0", {30'd0, pause_b}, 32'd1);
    chk("haz_stall_0", {31'd0, stall_b}, 32'd1);
    step();
    chk("haz_inflight_1", {28'd0, infl_b}, 32'd1);
    chk("haz_stall_1", {31'd0, stall_b}, 32'd1);
    step();
    chk("haz_inflight_2", {28'd0, infl_b}, 32'd1);
    chk("haz_stall_2", {31'd0, stall_b}, 32'd0);
    chk("haz_pause_2", {30'd0, pause_b}, 32'd0);
    step();
    chk("haz_inflight_3", {28'd0, infl_b}, 32'd0);
    rs_used = 1'b0; read_addr1 = 5'd0;

    // rt hazard gated by rt_used; both ports hazard -> 11.
    issue_valid = 1'b1; issue_addr = 5'd4;
    step();
    issue_valid = 1'b0;
    read_addr2 = 5'd4; rt_used = 1'b0;
    #1;
    chk("rt_unused_pause", {30'd0, pause_b}, 32'd0);
    rt_used = 1'b1; read_addr1 = 5'd4; rs_used = 1'b1;
    #1;
    chk("both_pause", {30'd0, pause_b}, 32'd3);
    chk("both_stall", {31'd0, stall_b}, 32'd1);

    // Issue during stall is dropped.
    issue_valid = 1'b1; issue_addr = 5'd6;
    step();
    chk("stall_issue_inflight", {28'd0, infl_b}, 32'd1);
    chk("stall_issue_still", {31'd0, stall_b}, 32'd1);

    // Reset mid-stall, with a write that reset must override.
    rst = 1'b0; RegWE = 1'b1; write_addr = 5'd10; write_data = 32'h0000FFFF;
    step();
    rst = 1'b1; RegWE = 1'b0; issue_valid = 1'b0;
    #1;
    chk("rst_stall_clear", {31'd0, stall_b}, 32'd0);
    chk("rst_pause_clear", {30'd0, pause_b}, 32'd0);
    chk("rst_inflight", {28'd0, infl_b}, 32'd0);
    read_addr1 = 5'd10; read_addr2 = 5'd7; rs_used = 1'b0; rt_used = 1'b0;
    #1;
    chk("rst_over_write_r10", rd1_b, 32'd0);
    chk("rst_clears_r7", rd2_b, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
